// File: rtl/iprefetch_pkg.sv
// iprefetch_pkg: shared state encoding, line geometry and address helper for the prefetcher
package iprefetch_pkg;
  localparam int LINE_BITS = 13;
  typedef enum logic [1:0] {PREF_IDLE, PREF_ISSUE, PREF_COOL, PREF_DONE} pref_state_t;
  function automatic logic [31:0] line_addr(input logic [LINE_BITS-1:0] line);
    return {16'b0, line, 3'b0};
  endfunction
endpackage

// File: rtl/iprefetch_if.sv
// iprefetch_if: fetch/icache-side signals of the next-line prefetcher
interface iprefetch_if;
  logic        squash;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic        dcache_request;
  logic        pref_hit_valid_line;
  logic [31:0] pref2Icache_addr;
  logic        pref2Icache_valid;
  modport master (
    output squash, fetch_addr, fetch_valid, dcache_request, pref_hit_valid_line,
    input  pref2Icache_addr, pref2Icache_valid
  );
  modport slave (
    input  squash, fetch_addr, fetch_valid, dcache_request, pref_hit_valid_line,
    output pref2Icache_addr, pref2Icache_valid
  );
endinterface

// File: rtl/iprefetch.sv
// iprefetch: next-line icache prefetcher issuing up to PREF_DEPTH lines ahead of fetch
module iprefetch
  import iprefetch_pkg::*;
#(
  parameter int PREF_DEPTH = 4,
  parameter int MISS_GAP   = 2
) (
  input logic clock,
  input logic reset,
  iprefetch_if.slave bus
);
  localparam int OFF_W = $clog2(PREF_DEPTH + 1);
  localparam int GAP_W = (MISS_GAP < 1) ? 1 : $clog2(MISS_GAP + 1);
  pref_state_t state, state_n;
  logic [LINE_BITS-1:0] base_line, base_n, line, fetch_line;
  logic [OFF_W-1:0] offset, offset_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic valid, line_change, last;
  logic unused_addr;
  assign unused_addr = ^{bus.fetch_addr[31:16], bus.fetch_addr[2:0]};
  assign fetch_line  = bus.fetch_addr[15:3];
  assign line        = base_line + LINE_BITS'(offset);
  assign valid       = (state == PREF_ISSUE) && !bus.dcache_request;
  assign line_change = bus.fetch_valid && (state == PREF_IDLE || fetch_line != base_line);
  assign last        = (offset == OFF_W'(PREF_DEPTH)) || (line == '1);
  assign bus.pref2Icache_valid = valid;
  assign bus.pref2Icache_addr  = valid ? line_addr(line) : 32'b0;
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= PREF_IDLE;
      base_line <= '0;
      offset    <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_n;
      base_line <= base_n;
      offset    <= offset_n;
      gap_cnt   <= gap_n;
    end
  end
  always_comb begin
    state_n  = state;
    base_n   = base_line;
    offset_n = offset;
    gap_n    = gap_cnt;
    if (bus.squash) begin
      state_n  = PREF_IDLE;
      offset_n = '0;
      gap_n    = '0;
    end else if (line_change) begin
      // a fetch line at the very top of the space has nothing ahead of it
      state_n  = (fetch_line == '1) ? PREF_DONE : PREF_ISSUE;
      base_n   = fetch_line;
      offset_n = OFF_W'(1);
      gap_n    = '0;
    end else if (valid) begin
      if (last) state_n = PREF_DONE;
      else begin
        offset_n = offset + OFF_W'(1);
        if (!bus.pref_hit_valid_line && MISS_GAP != 0) begin
          state_n = PREF_COOL;
          gap_n   = GAP_W'(MISS_GAP);
        end
      end
    end else if (state == PREF_COOL) begin
      gap_n   = gap_cnt - GAP_W'(1);
      state_n = (gap_cnt == GAP_W'(1)) ? PREF_ISSUE : PREF_COOL;
    end
  end
endmodule
